// File: rtl/multiplicador_fd_if.sv
// Control/status bundle between the shift-and-add multiplier controller and its datapath.
interface multiplicador_fd_if #(
  parameter int unsigned N = 4
);
  logic         a_rst;
  logic         a_en;
  logic         a_ld;
  logic         b_en;
  logic         b_ld;
  logic         q_en;
  logic         q_ld;
  logic         cnt_en;
  logic         cnt_ld;
  logic [N-1:0] mcand;
  logic [N-1:0] mplier;
  logic         qlsb;
  logic         zero;
  logic [2*N-1:0] product;

  modport master (
    output a_rst, a_en, a_ld, b_en, b_ld, q_en, q_ld, cnt_en, cnt_ld, mcand, mplier,
    input  qlsb, zero, product
  );

  modport slave (
    input  a_rst, a_en, a_ld, b_en, b_ld, q_en, q_ld, cnt_en, cnt_ld, mcand, mplier,
    output qlsb, zero, product
  );
endinterface

// File: rtl/multiplicador_fd.sv
// Shift-and-add unsigned multiplier datapath: {C,A,Q} accumulator/shifter, B operand, iteration
// counter. Every register is strobed independently by the controller.
module multiplicador_fd #(
  parameter int unsigned N = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  multiplicador_fd_if.slave   bus
);

  localparam int unsigned CW = (N > 2) ? $clog2(N) : 1;

  logic [N-1:0]  a_q, a_d;
  logic          c_q, c_d;
  logic [N-1:0]  b_q, b_d;
  logic [N-1:0]  q_q, q_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    a_d = a_q;
    c_d = c_q;
    if (bus.a_rst) begin
      a_d = '0;
      c_d = 1'b0;
    end else if (bus.a_en) begin
      if (bus.a_ld) begin
        {c_d, a_d} = {1'b0, a_q} + {1'b0, b_q};
      end else begin
        a_d = {c_q, a_q[N-1:1]};
        c_d = 1'b0;
      end
    end
  end

  // Q shifts in the pre-edge A[0], so {C,A,Q} moves as one wide shift register.
  always_comb begin
    q_d = q_q;
    if (bus.q_en) begin
      q_d = bus.q_ld ? bus.mplier : {a_q[0], q_q[N-1:1]};
    end
  end

  always_comb begin
    b_d = b_q;
    if (bus.b_en && bus.b_ld) begin
      b_d = bus.mcand;
    end
  end

  // Decrement wraps freely; the controller samples zero before the decrementing shift.
  always_comb begin
    cnt_d = cnt_q;
    if (bus.cnt_en) begin
      cnt_d = bus.cnt_ld ? CW'(N - 1) : cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_q   <= '0;
      c_q   <= 1'b0;
      b_q   <= '0;
      q_q   <= '0;
      cnt_q <= '0;
    end else begin
      a_q   <= a_d;
      c_q   <= c_d;
      b_q   <= b_d;
      q_q   <= q_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.qlsb    = q_q[0];
  assign bus.zero    = (cnt_q == '0);
  assign bus.product = {a_q, q_q};

endmodule
